// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 requester: valid/ready command in, one-cycle response out.
// Optional watchdog on ACCESS wait states is enabled by defining APB_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                  state_q,     state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    psel_q,      psel_d;
    logic                    penable_q,   penable_d;
    logic                    pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q,   rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0]        wait_cnt_q,  wait_cnt_d;
    logic                    rsp_tmo_q,   rsp_tmo_d;
`endif

    always_comb begin
        // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        rsp_tmo_d   = rsp_tmo_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is low for the first cycle out of reset, so gate on it.
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = ST_SETUP;
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
`ifdef APB_TIMEOUT_EN
                    rsp_tmo_d   = 1'b0;
`endif
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th wait state: give up on the slave.
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus and handshake outputs are decoded from the next state and registered.
        psel_d      = (state_d != ST_IDLE);
        penable_d   = (state_d == ST_ACCESS);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_tmo_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            rsp_tmo_q   <= rsp_tmo_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef APB_TIMEOUT_EN
    assign rsp_timeout = rsp_tmo_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master; the bench itself plays the APB slave.
// Covers reset, write/read, wait states, back-to-back, PSLVERR, watchdog (APB_TIMEOUT_EN) and reset abort.
module tb_apb_cmd_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TMO = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt  = 0;

    apb_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One transfer, starting in a cycle where cmd_ready is expected high and ending
    // in the response cycle. noisy_valid keeps cmd_valid high with junk during the transfer.
    task automatic do_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int waits,
                           input logic [DW-1:0] rdata, input logic slverr,
                           input logic noisy_valid);
        logic [DW-1:0] exp_pwdata;
        logic [DW-1:0] exp_rdata;
        exp_pwdata = wr ? wdata : '0;
        exp_rdata  = wr ? '0 : rdata;

        check({tag, "_ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();

        check({tag, "_setup_psel"}, PSEL, 1);
        check({tag, "_setup_penable"}, PENABLE, 0);
        check({tag, "_setup_ready"}, cmd_ready, 0);
        check({tag, "_setup_pwrite"}, PWRITE, wr);
        check({tag, "_setup_paddr"}, PADDR, addr);
        check({tag, "_setup_pwdata"}, PWDATA, exp_pwdata);
        if (noisy_valid) begin
            cmd_write = ~wr;
            cmd_addr  = ~addr;
            cmd_wdata = ~wdata;
        end else begin
            cmd_valid = 1'b0;
        end
        // Slave signals during SETUP must be ignored.
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = ~rdata;
        step();

        for (int k = 0; k <= waits; k++) begin
            check({tag, "_acc_psel"}, PSEL, 1);
            check({tag, "_acc_penable"}, PENABLE, 1);
            check({tag, "_acc_paddr"}, PADDR, addr);
            check({tag, "_acc_pwrite"}, PWRITE, wr);
            check({tag, "_acc_pwdata"}, PWDATA, exp_pwdata);
            check({tag, "_acc_rsp_valid"}, rsp_valid, 0);
            PREADY  = (k == waits);
            PSLVERR = (k == waits) ? slverr : 1'b1;
            PRDATA  = (k == waits) ? rdata : ~rdata;
            if (k == waits) cmd_valid = 1'b0;
            step();
        end

        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_rsp_err"}, rsp_err, slverr);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_rsp_psel"}, PSEL, 0);
        check({tag, "_rsp_penable"}, PENABLE, 0);
        check({tag, "_rsp_ready"}, cmd_ready, 1);
        check({tag, "_rsp_paddr_hold"}, PADDR, addr);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
    endtask

    initial begin
        int base;
        int n_acc;

        PRESETn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset
        #2 PRESETn = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        check("rel_cmd_ready_low", cmd_ready, 0);
        step();
        check("rel_cmd_ready", cmd_ready, 1);
        check("rel_psel", PSEL, 0);
        check("rel_pwrite", PWRITE, 0);
        check("rel_rsp_valid", rsp_valid, 0);
        check("rel_rsp_err", rsp_err, 0);
        check("rel_rsp_timeout", rsp_timeout, 0);

        // Write 0x4 = 0x20, no wait states; PRDATA junk must not reach rsp_rdata.
        do_xfer("wr4", 1'b1, 4'h4, 32'h20, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        check("wr4_pulse_end", rsp_valid, 0);

        // Read 0x4, 3 wait states with PSLVERR noise, cmd_valid held with junk.
        do_xfer("rd4", 1'b0, 4'h4, 32'hFFFF_FFFF, 3, 32'h20, 1'b0, 1'b1);
        step();
        check("rd4_pulse_end", rsp_valid, 0);
        check("rd4_rdata_hold", rsp_rdata, 32'h20);

        // Back-to-back: second command accepted in the first response cycle.
        base = rsp_cnt;
        do_xfer("b2b_wr0", 1'b1, 4'h0, 32'h1, 0, 32'h0, 1'b0, 1'b0);
        do_xfer("b2b_rd8", 1'b0, 4'h8, 32'h0, 0, 32'h55AA, 1'b0, 1'b0);
        step();
        check("b2b_rsp_count", rsp_cnt - base, 2);

        // PSLVERR on the final ACCESS cycle of a read.
        do_xfer("err_rdC", 1'b0, 4'hC, 32'h0, 1, 32'h1234_5678, 1'b1, 1'b0);
        step();
        check("err_hold", rsp_err, 1);

        // Slave that never becomes ready.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'h2;
        step();
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = 32'hA5A5_A5A5;
        base      = rsp_cnt;
        step();
`ifdef APB_TIMEOUT_EN
        n_acc = 0;
        while (PSEL === 1'b1 && PENABLE === 1'b1 && n_acc < 100) begin
            n_acc++;
            step();
        end
        check("tmo_access_cycles", n_acc, TMO);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_timeout", rsp_timeout, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        check("tmo_psel", PSEL, 0);
        step();
        check("tmo_pulse_end", rsp_valid, 0);
        cmd_valid = 1'b1;
        cmd_addr  = 4'h2;
        step();
        cmd_valid = 1'b0;
        base      = rsp_cnt;
        step();
`else
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (PSEL === 1'b1 && PENABLE === 1'b1) n_acc++;
            step();
        end
        check("stall_access_cycles", n_acc, 40);
        check("stall_no_rsp", rsp_cnt - base, 0);
        check("stall_timeout_tied", rsp_timeout, 0);
`endif

        // Reset in the middle of ACCESS aborts the transfer silently.
        repeat (3) step();
        check("abort_pre_penable", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        PREADY = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        PREADY = 1'b0;
        step();
        check("abort_rel_ready", cmd_ready, 1);
        check("abort_rel_psel", PSEL, 0);
        repeat (5) step();
        check("abort_no_rsp", rsp_cnt - base, 0);
        check("abort_idle_penable", PENABLE, 0);

        // Normal operation after the abort.
        do_xfer("post_rd6", 1'b0, 4'h6, 32'h0, 0, 32'hCAFE, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
